// File: rtl/lock_timer_pkg.sv
// lock_timer_pkg: shared FSM state type and timing defaults for the lock timer scheduler
package lock_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int TICK_DIV_1HZ = 40000000;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler (clk_in, rst async, clr sync, en) emitting a one-cycle tick every DIV enabled cycles
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int PW = $clog2(DIV);
  logic [PW-1:0] cnt;
  assign tick = en && (cnt == PW'(DIV - 1));
  always_ff @(posedge clk_in or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + PW'(1);
endmodule

// File: rtl/lock_timer_sched.sv
// lock_timer_sched: round-robin shared timeout timer; req/dur/cancel in, grant/done/busy/remaining/tick out
module lock_timer_sched
  import lock_timer_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int TICK_DIV = TICK_DIV_1HZ
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] dur,
  input  logic                     cancel,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         remaining,
  output logic                     tick
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state;
  logic [IW-1:0] rr, owner, sel, rr_next;
  logic any;
  logic [CNT_W-1:0] sel_dur;
  logic [NUM_REQ-1:0] sel_oh;
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[(int'(rr) + i) % NUM_REQ]) begin
        sel = IW'((int'(rr) + i) % NUM_REQ);
        any = 1'b1;
      end
  end
  assign sel_dur = dur[int'(sel)*CNT_W +: CNT_W];
  assign sel_oh  = NUM_REQ'(1) << sel;
  assign rr_next = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk_in (clk_in),
    .rst    (rst),
    .clr    (state != RUN),
    .en     (state == RUN),
    .tick   (tick)
  );
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      state     <= IDLE;
      rr        <= '0;
      owner     <= '0;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      remaining <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: if (any) begin
          owner     <= sel;
          remaining <= sel_dur;
          state     <= (sel_dur == '0) ? DONE : RUN;
          grant     <= (sel_dur == '0) ? '0 : sel_oh;
          busy      <= sel_dur != '0;
          done      <= (sel_dur == '0) ? sel_oh : '0;
        end
        RUN: if (cancel) begin
          state     <= IDLE;
          grant     <= '0;
          busy      <= 1'b0;
          remaining <= '0;
          rr        <= rr_next;
        end else if (tick) begin
          remaining <= remaining - CNT_W'(1);
          if (remaining <= CNT_W'(1)) begin
            state <= DONE;
            grant <= '0;
            busy  <= 1'b0;
            done  <= grant;
          end
        end
        DONE: begin
          state <= IDLE;
          rr    <= rr_next;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
